// File: rtl/serial_mult_pkg.sv
// Shared types and constants for the serial shift-add multiplier.
package serial_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/serial_mult_datapath.sv
// Operand registers, shift-add accumulator and bit counter; one multiplier bit per step.
module serial_mult_datapath #(
  parameter int WIDTH = serial_mult_pkg::DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_a,
  input  logic               load_b,
  input  logic               step,
  input  logic               clear,
  input  logic [WIDTH-1:0]   idata,
  output logic               last,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  assign last   = (cnt_q == CNT_W'(WIDTH - 1));
  assign addend = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
  // Sum for this bit; the final step writes it straight into result.
  assign acc_next = acc_q + addend;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (load_a) begin
      a_d = idata;
    end
    if (load_b) begin
      b_d   = idata;
      acc_d = '0;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_next;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        result_d = acc_next;
      end
    end
    if (clear) begin
      result_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/serial_mult.sv
// Unsigned WIDTHxWIDTH serial multiplier: two operand puts, WIDTH busy cycles, hold until get.
module serial_mult
  import serial_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               put,
  input  logic               get,
  input  logic [WIDTH-1:0]   idata,
  output logic               ready,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result,
  output state_e             dbg_state
);

  // Handshake: an operand transfers on a rising edge where put=1 and ready=1;
  // a result is consumed on a rising edge where get=1 and result_valid=1.
  // Strobes offered without the matching flag are ignored. ready and
  // result_valid decode the state register only, so neither depends on inputs.

  state_e state_q, state_d;
  logic   load_a, load_b, step, clear, last;

  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    step    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      LOAD_A: begin
        if (put) begin
          load_a  = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (put) begin
          load_b  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (get) begin
          clear   = 1'b1;
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  serial_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst_b),
    .load_a (load_a),
    .load_b (load_b),
    .step   (step),
    .clear  (clear),
    .idata  (idata),
    .last   (last),
    .result (result)
  );

  assign ready        = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign result_valid = (state_q == DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_mult.sv
// Directed-vector bench for serial_mult: each scenario task checks its own expectations.
module tb_serial_mult;
  import serial_mult_pkg::*;

  localparam int LAT = 8;
  localparam int WAIT_LIMIT = 20;

  logic        clk;
  logic        rst_b;
  logic        put;
  logic        get;
  logic [7:0]  idata;
  logic        ready;
  logic        result_valid;
  logic [15:0] result;
  state_e      dbg_state;

  int n_vec;
  int n_err;

  serial_mult #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .put          (put),
    .get          (get),
    .idata        (idata),
    .ready        (ready),
    .result_valid (result_valid),
    .result       (result),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_operand(input logic [7:0] d);
    put   = 1'b1;
    idata = d;
    tick();
    put   = 1'b0;
    idata = 8'h00;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!result_valid && cycles < WAIT_LIMIT) begin
      tick();
      cycles++;
    end
  endtask

  task automatic pulse_get();
    get = 1'b1;
    tick();
    get = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    rst_b = 1'b1;
    tick();
    tick();
    n_vec++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || result !== 16'd0 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL reset ready=%0b rv=%0b result=%0d state=%0d exp ready=1 rv=0 result=0 state=0",
               ready, result_valid, result, dbg_state);
    end
    rst_b = 1'b0;
    tick();
    n_vec++;
    if (ready !== 1'b1 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL reset_release ready=%0b state=%0d exp ready=1 state=0", ready, dbg_state);
    end
  endtask

  task automatic test_basic();
    put_operand(8'd5);
    n_vec++;
    if (ready !== 1'b1 || dbg_state !== LOAD_B) begin
      n_err++;
      $display("FAIL basic_after_a ready=%0b state=%0d exp ready=1 state=1", ready, dbg_state);
    end
    put_operand(8'd3);
    for (int k = 0; k < LAT; k++) begin
      n_vec++;
      if (ready !== 1'b0 || result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy cycle=%0d ready=%0b rv=%0b exp ready=0 rv=0", k, ready, result_valid);
      end
      tick();
    end
    n_vec++;
    if (result_valid !== 1'b1 || result !== 16'd15 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result rv=%0b result=%0d ready=%0b exp rv=1 result=15 ready=0",
               result_valid, result, ready);
    end
    pulse_get();
    n_vec++;
    if (result_valid !== 1'b0 || ready !== 1'b1 || result !== 16'd0) begin
      n_err++;
      $display("FAIL basic_get rv=%0b ready=%0b result=%0d exp rv=0 ready=1 result=0",
               result_valid, ready, result);
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  va [3] = '{8'd255, 8'd0,   8'd1};
    logic [7:0]  vb [3] = '{8'd255, 8'd200, 8'd128};
    logic [15:0] ve [3] = '{16'hFE01, 16'd0, 16'd128};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      put_operand(va[i]);
      put_operand(vb[i]);
      wait_valid(cyc);
      n_vec++;
      if (cyc != LAT || result !== ve[i]) begin
        n_err++;
        $display("FAIL extreme_%0d latency=%0d result=%0d exp latency=%0d result=%0d",
                 i, cyc, result, LAT, ve[i]);
      end
      pulse_get();
    end
  endtask

  task automatic test_put_busy();
    int cyc;
    put_operand(8'd6);
    put_operand(8'd7);
    put   = 1'b1;
    idata = 8'd9;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (ready !== 1'b0 || dbg_state !== BUSY) begin
        n_err++;
        $display("FAIL put_busy_state cycle=%0d ready=%0b state=%0d exp ready=0 state=2",
                 k, ready, dbg_state);
      end
      tick();
    end
    put   = 1'b0;
    idata = 8'd0;
    wait_valid(cyc);
    n_vec++;
    if (cyc != LAT - 3 || result !== 16'd42) begin
      n_err++;
      $display("FAIL put_busy_result wait=%0d result=%0d exp wait=%0d result=42", cyc, result, LAT - 3);
    end
    pulse_get();
  endtask

  task automatic test_get_early();
    int cyc;
    pulse_get();
    n_vec++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL get_early_load_a ready=%0b rv=%0b state=%0d exp ready=1 rv=0 state=0",
               ready, result_valid, dbg_state);
    end
    put_operand(8'd4);
    pulse_get();
    n_vec++;
    if (dbg_state !== LOAD_B || ready !== 1'b1) begin
      n_err++;
      $display("FAIL get_early_load_b state=%0d ready=%0b exp state=1 ready=1", dbg_state, ready);
    end
    put_operand(8'd5);
    pulse_get();
    wait_valid(cyc);
    n_vec++;
    if (cyc != LAT - 1 || result !== 16'd20) begin
      n_err++;
      $display("FAIL get_early_result wait=%0d result=%0d exp wait=%0d result=20", cyc, result, LAT - 1);
    end
    pulse_get();
  endtask

  task automatic test_put_done();
    int cyc;
    put_operand(8'd3);
    put_operand(8'd3);
    wait_valid(cyc);
    put   = 1'b1;
    idata = 8'd77;
    tick();
    tick();
    n_vec++;
    if (result_valid !== 1'b1 || result !== 16'd9 || dbg_state !== DONE || ready !== 1'b0) begin
      n_err++;
      $display("FAIL put_done_hold rv=%0b result=%0d state=%0d ready=%0b exp rv=1 result=9 state=3 ready=0",
               result_valid, result, dbg_state, ready);
    end
    idata = 8'd50;
    get   = 1'b1;
    tick();
    put   = 1'b0;
    get   = 1'b0;
    idata = 8'd0;
    n_vec++;
    if (result_valid !== 1'b0 || ready !== 1'b1 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL put_get_done rv=%0b ready=%0b state=%0d exp rv=0 ready=1 state=0",
               result_valid, ready, dbg_state);
    end
    put_operand(8'd2);
    put_operand(8'd3);
    wait_valid(cyc);
    n_vec++;
    if (cyc != LAT || result !== 16'd6) begin
      n_err++;
      $display("FAIL put_done_next latency=%0d result=%0d exp latency=%0d result=6", cyc, result, LAT);
    end
    pulse_get();
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit rose;
    put_operand(8'd200);
    put_operand(8'd100);
    tick();
    tick();
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    n_vec++;
    if (ready !== 1'b1 || result_valid !== 1'b0 || result !== 16'd0 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL reset_mid ready=%0b rv=%0b result=%0d state=%0d exp ready=1 rv=0 result=0 state=0",
               ready, result_valid, result, dbg_state);
    end
    rose = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (result_valid === 1'b1) rose = 1'b1;
      tick();
    end
    n_vec++;
    if (rose !== 1'b0 || dbg_state !== LOAD_A) begin
      n_err++;
      $display("FAIL reset_mid_quiet rose=%0b state=%0d exp rose=0 state=0", rose, dbg_state);
    end
    put_operand(8'd12);
    put_operand(8'd12);
    wait_valid(cyc);
    n_vec++;
    if (cyc != LAT || result !== 16'd144) begin
      n_err++;
      $display("FAIL reset_mid_next latency=%0d result=%0d exp latency=%0d result=144", cyc, result, LAT);
    end
    pulse_get();
  endtask

  task automatic test_back_to_back();
    int cyc;
    put_operand(8'd7);
    put_operand(8'd9);
    wait_valid(cyc);
    n_vec++;
    if (result !== 16'd63) begin
      n_err++;
      $display("FAIL b2b_first result=%0d exp 63", result);
    end
    pulse_get();
    put_operand(8'd10);
    n_vec++;
    if (result !== 16'd0 || result_valid !== 1'b0 || dbg_state !== LOAD_B) begin
      n_err++;
      $display("FAIL b2b_cleared result=%0d rv=%0b state=%0d exp result=0 rv=0 state=1",
               result, result_valid, dbg_state);
    end
    put_operand(8'd10);
    wait_valid(cyc);
    n_vec++;
    if (cyc != LAT || result !== 16'd100) begin
      n_err++;
      $display("FAIL b2b_second latency=%0d result=%0d exp latency=%0d result=100", cyc, result, LAT);
    end
    pulse_get();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_b = 1'b1;
    put   = 1'b0;
    get   = 1'b0;
    idata = 8'd0;
    #1;
    test_reset();
    test_basic();
    test_extremes();
    test_put_busy();
    test_get_early();
    test_put_done();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
